fixed_integer_matvec_sequencer: RTL and testbench
=================================================

// Module: fixed_integer_matvec_sequencer
// PURPOSE
//  Sequences the fixed-integer dot-product unit (dp_* port group) to compute y = W*x for a ROWS x LENGTH matrix.
//  Buffers x once, streams weight rows into the unit's shift-loaded A vector, then streams x chunks.
//  Captures each row result and emits it on a valid/ready result stream.
//  Sits between the weight/input stream sources and the layer output FIFO.
// PARAMETERS
//  BITS    16  element/result width (two's complement)
//  LENGTH  10  elements per row / per x; LENGTH % MULTS == 0 (elaboration $error otherwise)
//  MULTS    2  elements per beat (dp parallelism); CHUNKS = LENGTH/MULTS
//  ROWS     4  matrix rows per job
// PORTS
//  clk             in   1            clock
//  rstn            in   1            async active-low reset
//  start           in   1            job start pulse; sampled in IDLE only
//  busy            out  1            high from cycle after accepted start until DONE exit
//  done            out  1            1-cycle pulse after last result handshake
//  err             out  1            sticky: dp_out_valid seen outside WAIT; cleared by start
//  x_valid/x_ready in/out 1          input-vector chunk stream handshake
//  x_data          in   MULTS*BITS   x chunk, element i at [i*BITS +: BITS]
//  w_valid/w_ready in/out 1          weight chunk stream, row-major, chunk 0 first
//  w_data          in   MULTS*BITS   weight chunk
//  dp_load_a       out  1            shift one weight chunk into dp
//  dp_vector_a_in  out  MULTS*BITS   weight chunk to dp
//  dp_in_valid     out  1            dp operand beat
//  dp_vector_b     out  MULTS*BITS   x chunk to dp
//  dp_out_valid    in   1            dp result strobe
//  dp_c            in   BITS         dp result
//  r_valid/r_ready out/in 1          result stream handshake
//  r_data          out  BITS         row result
//  r_row           out  $clog2(ROWS) row index of r_data
// BEHAVIOUR
//  Reset: state IDLE; busy, done, err, x_ready, w_ready, dp_load_a, dp_in_valid, r_valid = 0; r_data, r_row,
//   chunk/row counters = 0. dp instance shares rstn; its chunk counter clears with it, so reset mid-job is safe.
//  FSM: IDLE -start-> LOAD_X -CHUNKS x beats-> LOAD_W -CHUNKS w beats-> STREAM -CHUNKS beats-> WAIT
//   -dp_out_valid-> EMIT -r_valid&r_ready-> (row==ROWS-1 ? DONE : LOAD_W, row+1); DONE -> IDLE (1 cycle, done=1).
//  LOAD_X: x_ready=1; each x_valid&x_ready writes chunk k (k=0..CHUNKS-1) to buffer.
//  LOAD_W: w_ready=1; dp_load_a = w_valid&w_ready, dp_vector_a_in = w_data (combinational pass-through);
//   bubbles allowed, only handshaken beats count.
//  STREAM: dp_in_valid=1 every cycle for exactly CHUNKS cycles; beat j drives x chunk CHUNKS-1-j (reverse order,
//   because dp's A shift register holds the last-loaded chunk at position 0). Never fewer or more beats.
//  WAIT: unbounded; first dp_out_valid captures dp_c into r_data (through optional ReLU), r_row = row.
//  EMIT: r_valid held with stable r_data/r_row until r_ready; no new dp traffic meanwhile.
//  dp_load_a and dp_in_valid never asserted in the same cycle.
//  start while busy: ignored. start in DONE cycle: ignored (taken next IDLE cycle).
//  dp_out_valid outside WAIT: sets err, data dropped, FSM unaffected.
//  Results are raw dp_c bits (no rescale); counters wrap only via FSM transitions, not arithmetic overflow.
//  Throughput per row: >= 2*CHUNKS + dp latency + 1 cycles; x loaded once per job.
// CONFIGURATION
//  FIXED_MATVEC_RELU_EN defined: r_data = dp_c[BITS-1] ? '0 : dp_c (signed ReLU at capture).
//  Undefined: r_data = dp_c unchanged. No other behaviour or timing differs.
// STRUCTURE
//  Package fixed_matvec_pkg: state_t enum {IDLE,LOAD_X,LOAD_W,STREAM,WAIT,EMIT,DONE}; function relu(BITS).
//  Sub-module fixed_matvec_x_buffer: CHUNKS x MULTS x BITS regs, one write port (chunk idx),
//   one async read port (chunk idx); no reset on storage.
//  Top keeps FSM, chunk counter ($clog2(CHUNKS)+1 bits), row counter, result register.
// TESTING  (dp unit instantiated; LENGTH=4, MULTS=2, ROWS=2, BITS=16 unless stated)
//  1 x=[1,2,3,4], W rows [1,1,1,1],[1,0,0,2], r_ready=1 -> r=(10,row0),(9,row1), done pulse once, busy low after.
//  2 Same job, r_ready low 20 cycles on row0 -> r_valid/r_data=10 stable, no dp_load_a/in_valid until accepted.
//  3 w_valid toggling every other cycle -> exactly CHUNKS dp_load_a pulses per row, results unchanged.
//  4 x=[-1,0,0,0], W row0 [5,0,0,0] -> r_data 0xFFFB; with FIXED_MATVEC_RELU_EN -> 0x0000.
//  5 rstn low during STREAM of row1, then rerun test 1 -> results 10,9; err=0.
//  6 start pulsed while busy and spurious dp_out_valid in LOAD_W -> second start ignored, err=1, results correct.

Source files
------------

// File: rtl/fixed_matvec_pkg.sv
// ============================================================================
// Module   : fixed_matvec_pkg
// Purpose  : Shared FSM state encoding and ReLU helper for the mat-vec sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fixed_matvec_pkg;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_load_x = 3'd1;
  localparam logic [2:0] c_st_load_w = 3'd2;
  localparam logic [2:0] c_st_stream = 3'd3;
  localparam logic [2:0] c_st_wait   = 3'd4;
  localparam logic [2:0] c_st_emit   = 3'd5;
  localparam logic [2:0] c_st_done   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = c_st_idle,
    LOAD_X = c_st_load_x,
    LOAD_W = c_st_load_w,
    STREAM = c_st_stream,
    WAIT   = c_st_wait,
    EMIT   = c_st_emit,
    DONE   = c_st_done
  } state_t;

  // Signed ReLU on the low (sign_pos+1) bits of value; callers keep only those bits.
  function automatic logic [63:0] relu(input logic [63:0] value, input logic [5:0] sign_pos);
    return value[sign_pos] ? 64'd0 : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fixed_matvec_x_buffer.sv
// ============================================================================
// Module   : fixed_matvec_x_buffer
// Purpose  : Holds the x vector as CHUNKS words; one write port, one async read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_matvec_x_buffer
  import fixed_matvec_pkg::*;
#(
  parameter int CHUNKS = 5,
  parameter int WIDTH  = 32,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  // Storage is deliberately unreset: x is always fully rewritten before it is read.
  logic [WIDTH-1:0] r_mem [CHUNKS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/fixed_integer_matvec_sequencer.sv
// ============================================================================
// Module   : fixed_integer_matvec_sequencer
// Purpose  : Drives a fixed-integer dot-product unit to compute y = W*x row by row.
//            Optional FIXED_MATVEC_RELU_EN applies a signed ReLU at result capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_integer_matvec_sequencer
  import fixed_matvec_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int LENGTH = 10,
  parameter int MULTS  = 2,
  parameter int ROWS   = 4,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [MULTS*BITS-1:0] x_data,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [MULTS*BITS-1:0] w_data,
  output logic                  dp_load_a,
  output logic [MULTS*BITS-1:0] dp_vector_a_in,
  output logic                  dp_in_valid,
  output logic [MULTS*BITS-1:0] dp_vector_b,
  input  logic                  dp_out_valid,
  input  logic [BITS-1:0]       dp_c,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [BITS-1:0]       r_data,
  output logic [ROW_W-1:0]      r_row
);

  localparam int CHUNKS = LENGTH / MULTS;
  localparam int CNT_W  = $clog2(CHUNKS) + 1;
  localparam int VEC_W  = MULTS * BITS;
  localparam logic [CNT_W-1:0] c_last_chunk = CNT_W'(CHUNKS - 1);
  localparam logic [ROW_W-1:0] c_last_row   = ROW_W'(ROWS - 1);

  generate
    if (LENGTH % MULTS != 0) begin : g_bad_cfg
      $error("fixed_integer_matvec_sequencer: LENGTH must be a multiple of MULTS");
    end
  endgenerate

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_chunk;
  logic [ROW_W-1:0]  r_row_cnt;
  logic              r_err;
  logic              w_start, w_x_beat, w_w_beat, w_s_beat, w_beat;
  logic              w_chunk_last, w_capture, w_accept, w_spurious;
  logic [CNT_W-1:0]  w_rd_idx;
  logic [VEC_W-1:0]  w_rd_data;
  logic [BITS-1:0]   w_result;

  assign w_start      = (r_state == IDLE) && start;
  assign w_x_beat     = (r_state == LOAD_X) && x_valid;
  assign w_w_beat     = (r_state == LOAD_W) && w_valid;
  assign w_s_beat     = (r_state == STREAM);
  assign w_beat       = w_x_beat || w_w_beat || w_s_beat;
  assign w_chunk_last = (r_chunk == c_last_chunk);
  assign w_capture    = (r_state == WAIT) && dp_out_valid;
  assign w_accept     = (r_state == EMIT) && r_ready;
  assign w_spurious   = dp_out_valid && (r_state != WAIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = LOAD_X;
      LOAD_X:  if (w_x_beat && w_chunk_last) w_next = LOAD_W;
      LOAD_W:  if (w_w_beat && w_chunk_last) w_next = STREAM;
      STREAM:  if (w_chunk_last) w_next = WAIT;
      WAIT:    if (dp_out_valid) w_next = EMIT;
      EMIT:    if (r_ready) w_next = (r_row_cnt == c_last_row) ? DONE : LOAD_W;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_chunk   <= '0;
      r_row_cnt <= '0;
      r_err     <= 1'b0;
      r_data    <= '0;
      r_row     <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_chunk <= '0;
      end else if (w_beat) begin
        r_chunk <= w_chunk_last ? '0 : r_chunk + 1'b1;
      end
      if (w_start) begin
        r_row_cnt <= '0;
      end else if (w_accept) begin
        r_row_cnt <= (r_row_cnt == c_last_row) ? '0 : r_row_cnt + 1'b1;
      end
      r_err <= (r_err && !w_start) || w_spurious;
      if (w_capture) begin
        r_data <= w_result;
        r_row  <= r_row_cnt;
      end
    end
  end

`ifdef FIXED_MATVEC_RELU_EN
  logic [63:0] w_relu_full;
  assign w_relu_full = relu(64'(dp_c), 6'(BITS - 1));
  assign w_result    = w_relu_full[BITS-1:0];
`else
  assign w_result = dp_c;
`endif

  // The dp A register holds the last-loaded chunk at position 0, so x is replayed backwards.
  assign w_rd_idx = c_last_chunk - r_chunk;

  fixed_matvec_x_buffer #(
    .CHUNKS (CHUNKS),
    .WIDTH  (VEC_W),
    .IDX_W  (CNT_W)
  ) u_x_buffer (
    .clk     (clk),
    .wr_en   (w_x_beat),
    .wr_idx  (r_chunk),
    .wr_data (x_data),
    .rd_idx  (w_rd_idx),
    .rd_data (w_rd_data)
  );

  assign busy           = (r_state != IDLE);
  assign done           = (r_state == DONE);
  assign err            = r_err;
  assign x_ready        = (r_state == LOAD_X);
  assign w_ready        = (r_state == LOAD_W);
  assign dp_load_a      = w_w_beat;
  assign dp_vector_a_in = w_data;
  assign dp_in_valid    = w_s_beat;
  assign dp_vector_b    = w_s_beat ? w_rd_data : '0;
  assign r_valid        = (r_state == EMIT);

endmodule

`default_nettype wire

// File: tb/tb_fixed_integer_matvec_sequencer.sv
// ============================================================================
// Module   : tb_fixed_integer_matvec_sequencer
// Purpose  : Directed self-checking bench with a behavioural dot-product unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_integer_matvec_sequencer;

  localparam int BITS   = 16;
  localparam int LENGTH = 4;
  localparam int MULTS  = 2;
  localparam int ROWS   = 2;
  localparam int CHUNKS = LENGTH / MULTS;
  localparam int VEC_W  = MULTS * BITS;

  logic             clk = 1'b0;
  logic             rstn, start, x_valid, w_valid, r_ready;
  logic [VEC_W-1:0] x_data, w_data;
  logic             busy, done, err, x_ready, w_ready;
  logic             dp_load_a, dp_in_valid, dp_out_valid, r_valid;
  logic [VEC_W-1:0] dp_vector_a_in, dp_vector_b;
  logic [BITS-1:0]  dp_c, r_data;
  logic [0:0]       r_row;
  logic             dp_inj;

  fixed_integer_matvec_sequencer #(
    .BITS(BITS), .LENGTH(LENGTH), .MULTS(MULTS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err(err),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .dp_load_a(dp_load_a), .dp_vector_a_in(dp_vector_a_in), .dp_in_valid(dp_in_valid),
    .dp_vector_b(dp_vector_b), .dp_out_valid(dp_out_valid), .dp_c(dp_c),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_row(r_row)
  );

  always #5 clk = ~clk;

  // Behavioural dp unit: shift-loaded A, CHUNKS operand beats, two-cycle result latency.
  logic [VEC_W-1:0]   m_a [CHUNKS];
  logic signed [31:0] m_acc, m_prod, m_s1, m_s2;
  logic               m_v1, m_v2;
  int                 m_cnt;

  always_comb begin
    m_prod = 32'sd0;
    for (int i = 0; i < MULTS; i++) begin
      m_prod = m_prod + 32'(signed'(m_a[m_cnt][i*BITS +: BITS])) *
                        32'(signed'(dp_vector_b[i*BITS +: BITS]));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CHUNKS; i++) m_a[i] <= '0;
      m_acc <= 0; m_cnt <= 0; m_v1 <= 1'b0; m_v2 <= 1'b0; m_s1 <= 0; m_s2 <= 0;
    end else begin
      if (dp_load_a) begin
        m_a[0] <= dp_vector_a_in;
        for (int i = 1; i < CHUNKS; i++) m_a[i] <= m_a[i-1];
      end
      m_v1 <= 1'b0;
      if (dp_in_valid) begin
        if (m_cnt == CHUNKS - 1) begin
          m_cnt <= 0; m_acc <= 0; m_v1 <= 1'b1; m_s1 <= m_acc + m_prod;
        end else begin
          m_cnt <= m_cnt + 1; m_acc <= m_acc + m_prod;
        end
      end
      m_v2 <= m_v1;
      m_s2 <= m_s1;
    end
  end

  assign dp_out_valid = m_v2 | dp_inj;
  assign dp_c         = dp_inj ? 16'h1234 : m_s2[BITS-1:0];

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] x_vec  [LENGTH];
  logic [15:0] w_flat [ROWS*LENGTH];
  logic [15:0] res_data [4];
  logic [15:0] res_row  [4];
  int          nres, done_cnt, loads, overlap, hold, quiet_bad, unstable;
  logic        busy_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_job(input logic [15:0] x0, x1, x2, x3,
                         input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    x_vec[0] = x0; x_vec[1] = x1; x_vec[2] = x2; x_vec[3] = x3;
    w_flat[0] = a0; w_flat[1] = a1; w_flat[2] = a2; w_flat[3] = a3;
    w_flat[4] = b0; w_flat[5] = b1; w_flat[6] = b2; w_flat[7] = b3;
  endtask

  task automatic run_job(input int stall_row0, input bit w_toggle,
                         input bit abort_row1, input bit spurious);
    int x_ptr = 0, w_ptr = 0, cyc = 0, post = 0;
    bit injected = 0;
    logic [15:0] first_data = '0;
    bit first_seen = 0;
    nres = 0; done_cnt = 0; loads = 0; overlap = 0; hold = 0; quiet_bad = 0; unstable = 0;
    @(negedge clk); start = 1'b1;
    while (cyc < 300 && post < 3) begin
      @(negedge clk);
      cyc++;
      start  = spurious && (cyc == 3);
      dp_inj = 1'b0;
      x_valid = (x_ptr < CHUNKS);
      x_data  = x_valid ? {x_vec[2*x_ptr+1], x_vec[2*x_ptr]} : '0;
      w_valid = (w_ptr < ROWS*CHUNKS) && (!w_toggle || cyc[0]);
      w_data  = (w_ptr < ROWS*CHUNKS) ? {w_flat[2*w_ptr+1], w_flat[2*w_ptr]} : '0;
      r_ready = !(nres == 0 && hold < stall_row0);
      if (spurious && !injected && w_ready) begin
        dp_inj = 1'b1; injected = 1;
      end
      #1;
      if (cyc == 1) busy_first = busy;
      if (dp_load_a && dp_in_valid) overlap++;
      if (dp_load_a) loads++;
      if (r_valid && !r_ready) begin
        hold++;
        if (!first_seen) begin first_data = r_data; first_seen = 1; end
        if (r_data !== first_data || r_row !== 1'b0) unstable++;
        if (dp_load_a || dp_in_valid) quiet_bad++;
      end
      if (x_valid && x_ready) x_ptr++;
      if (w_valid && w_ready) w_ptr++;
      if (r_valid && r_ready && nres < 4) begin
        res_data[nres] = r_data; res_row[nres] = 16'(r_row); nres++;
      end
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
      if (abort_row1 && nres == 1 && dp_in_valid) begin
        rstn = 1'b0;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0; x_valid = 1'b0; w_valid = 1'b0; dp_inj = 1'b0; r_ready = 1'b1;
  endtask

  task automatic check_pair(input string tag, input logic [15:0] e0, input logic [15:0] e1);
    check({tag, " nres"}, 32'(nres), 32'd2);
    check({tag, " r0"}, {res_row[0], res_data[0]}, {16'd0, e0});
    check({tag, " r1"}, {res_row[1], res_data[1]}, {16'd1, e1});
    check({tag, " done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " overlap"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; x_valid = 1'b0; w_valid = 1'b0; r_ready = 1'b0;
    x_data = '0; w_data = '0; dp_inj = 1'b0; busy_first = 1'b0;
    for (int i = 0; i < 4; i++) begin res_data[i] = '0; res_row[i] = '0; end
    repeat (2) @(negedge clk);
    check("reset ctl", {24'd0, busy, done, err, x_ready, w_ready, dp_load_a, dp_in_valid, r_valid}, 32'd0);
    check("reset data", {15'd0, r_row, r_data}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Basic job: 1+2+3+4 = 10 and 1*1 + 4*2 = 9
    set_job(16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2);
    run_job(0, 1'b0, 1'b0, 1'b0);
    check("t1 busy_first", 32'(busy_first), 32'd1);
    check_pair("t1", 16'd10, 16'd9);
    check("t1 loads", 32'(loads), 32'd4);
    check("t1 err", 32'(err), 32'd0);

    // Back-pressure on row 0 result
    run_job(20, 1'b0, 1'b0, 1'b0);
    check_pair("t2", 16'd10, 16'd9);
    check("t2 hold", 32'(hold), 32'd20);
    check("t2 unstable", 32'(unstable), 32'd0);
    check("t2 quiet", 32'(quiet_bad), 32'd0);

    // Weight stream with bubbles
    run_job(0, 1'b1, 1'b0, 1'b0);
    check_pair("t3", 16'd10, 16'd9);
    check("t3 loads", 32'(loads), 32'd4);

    // Negative result: -1 * 5 = -5
    set_job(16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    run_job(0, 1'b0, 1'b0, 1'b0);
`ifdef FIXED_MATVEC_RELU_EN
    check_pair("t4", 16'h0000, 16'h0000);
`else
    check_pair("t4", 16'hFFFB, 16'h0000);
`endif

    // Reset while row 1 is streaming, then a clean rerun
    set_job(16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2);
    run_job(0, 1'b0, 1'b1, 1'b0);
    check("t5 in_reset", {28'd0, busy, dp_in_valid, r_valid, err}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    run_job(0, 1'b0, 1'b0, 1'b0);
    check_pair("t5", 16'd10, 16'd9);
    check("t5 err", 32'(err), 32'd0);

    // Start while busy plus a stray dp result in LOAD_W
    run_job(0, 1'b0, 1'b0, 1'b1);
    check_pair("t6", 16'd10, 16'd9);
    check("t6 err", 32'(err), 32'd1);

    // A fresh start clears the sticky error
    run_job(0, 1'b0, 1'b0, 1'b0);
    check_pair("t7", 16'd10, 16'd9);
    check("t7 err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
